// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers, level and full/empty flags.
// A push into a full FIFO is accepted when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [DEPTH:0]   level,
  output logic             full,
  output logic             empty
);

  localparam int ENTRIES = 2 ** DEPTH;

  logic [WIDTH-1:0] r_mem [ENTRIES];
  logic [DEPTH-1:0] r_wr_ptr;
  logic [DEPTH-1:0] r_rd_ptr;
  logic [DEPTH:0]   r_level;
  logic             r_full;
  logic             r_empty;

  logic             w_do_push;
  logic             w_do_pop;
  logic [DEPTH:0]   w_level_nxt;

  assign w_do_pop  = pop && !r_empty;
  assign w_do_push = push && (!r_full || w_do_pop);

  // NOTE: assign a default before any branch so always_comb never infers a latch.
  always_comb begin
    w_level_nxt = r_level;
    if (w_do_push && !w_do_pop) begin
      w_level_nxt = r_level + (DEPTH+1)'(1);
    end else if (!w_do_push && w_do_pop) begin
      w_level_nxt = r_level - (DEPTH+1)'(1);
    end
  end

  // NOTE: sequential state uses <= so every flop samples values from before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + DEPTH'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + DEPTH'(1);
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == (DEPTH+1)'(ENTRIES));
      r_empty <= (w_level_nxt == '0);
    end
  end

  // NOTE: storage is not reset; pointers and level alone decide what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

  assign rdata = r_mem[r_rd_ptr];
  assign level = r_level;
  assign full  = r_full;
  assign empty = r_empty;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter on the core's store port. Bytes written
// while the buffer is full are dropped and latched into a sticky overflow flag.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         uart_dout,
  input  logic                uart_we,
  input  logic                clear_overflow,
  output logic                txd,
  output logic                busy,
  output logic [FIFO_DEPTH:0] fifo_level,
  output logic                overflow
);

  localparam int BCNT_W   = $clog2(CLKS_PER_BIT);
  localparam int BITCNT_W = $clog2(UART_DATA_BITS);

  tx_state_t                 r_state;
  logic [BCNT_W-1:0]         r_bcnt;
  logic [BITCNT_W-1:0]       r_bitcnt;
  logic [UART_DATA_BITS-1:0] r_shreg;
  logic                      r_txd;
  logic                      r_overflow;

  tx_state_t                 w_state_nxt;
  logic [BCNT_W-1:0]         w_bcnt_nxt;
  logic [BITCNT_W-1:0]       w_bitcnt_nxt;
  logic [UART_DATA_BITS-1:0] w_shreg_nxt;
  logic                      w_txd_nxt;
  logic                      w_pop;
  logic                      w_bit_end;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_drop;
  logic [UART_DATA_BITS-1:0] w_rdata;
  logic                      w_unused_dout;

  assign w_unused_dout = ^uart_dout[31:UART_DATA_BITS];

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (uart_we),
    .pop   (w_pop),
    .wdata (uart_dout[UART_DATA_BITS-1:0]),
    .rdata (w_rdata),
    .level (fifo_level),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_bit_end = (r_bcnt == BCNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    w_state_nxt  = r_state;
    w_bcnt_nxt   = r_bcnt + BCNT_W'(1);
    w_bitcnt_nxt = r_bitcnt;
    w_shreg_nxt  = r_shreg;
    w_txd_nxt    = r_txd;
    w_pop        = 1'b0;
    case (r_state)
      TX_IDLE: begin
        w_bcnt_nxt = '0;
        w_txd_nxt  = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shreg_nxt = w_rdata;
          w_txd_nxt   = 1'b0;
          w_state_nxt = TX_START;
        end
      end
      TX_START: begin
        if (w_bit_end) begin
          w_bcnt_nxt   = '0;
          w_bitcnt_nxt = '0;
          w_txd_nxt    = r_shreg[0];
          w_state_nxt  = TX_DATA;
        end
      end
      TX_DATA: begin
        if (w_bit_end) begin
          w_bcnt_nxt = '0;
          if (r_bitcnt == BITCNT_W'(UART_DATA_BITS - 1)) begin
            w_txd_nxt   = 1'b1;
            w_state_nxt = TX_STOP;
          end else begin
            // Next data bit goes straight into the txd flop, so it is r_shreg[1] pre-shift.
            w_shreg_nxt  = r_shreg >> 1;
            w_txd_nxt    = r_shreg[1];
            w_bitcnt_nxt = r_bitcnt + BITCNT_W'(1);
          end
        end
      end
      TX_STOP: begin
        if (w_bit_end) begin
          w_bcnt_nxt  = '0;
          w_state_nxt = TX_IDLE;
        end
      end
      default: begin
        w_bcnt_nxt  = '0;
        w_txd_nxt   = 1'b1;
        w_state_nxt = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= TX_IDLE;
      r_bcnt   <= '0;
      r_bitcnt <= '0;
      r_shreg  <= '0;
      r_txd    <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_bcnt   <= w_bcnt_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_shreg  <= w_shreg_nxt;
      r_txd    <= w_txd_nxt;
    end
  end

  assign w_drop = uart_we && w_full && !w_pop;

  // A drop on the same edge as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clear_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign txd      = r_txd;
  assign overflow = r_overflow;
  assign busy     = (r_state != TX_IDLE) || !w_empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLKS_PER_BIT=4 and a 4-entry buffer.
// Each txd sample is logged by edge index so frame timing can be checked exactly.
module tb_uart_tx_fifo;

  localparam int CPB    = 4;
  localparam int FD     = 2;
  localparam int FRAME  = 10 * CPB;
  localparam int PERIOD = FRAME + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   uart_dout = '0;
  logic          uart_we = 1'b0;
  logic          clear_overflow = 1'b0;
  logic          txd;
  logic          busy;
  logic [FD:0]   fifo_level;
  logic          overflow;

  int            n_checks = 0;
  int            n_errors = 0;

  logic          cap [300];
  int            cap_idx;
  logic [FD:0]   peak_level;
  logic          ovf_seen;

  uart_tx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .uart_dout      (uart_dout),
    .uart_we        (uart_we),
    .clear_overflow (clear_overflow),
    .txd            (txd),
    .busy           (busy),
    .fifo_level     (fifo_level),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before the summary line");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advances one edge and logs txd at index "edges since the test's edge 0".
  task automatic tick_rec();
    tick();
    cap[cap_idx] = txd;
    cap_idx++;
    if (fifo_level > peak_level) peak_level = fifo_level;
    if (overflow) ovf_seen = 1'b1;
  endtask

  task automatic start_log();
    cap_idx    = 0;
    peak_level = '0;
    ovf_seen   = 1'b0;
  endtask

  function automatic logic [7:0] decode(input int s);
    logic [7:0] d;
    for (int i = 0; i < 8; i++) d[i] = cap[s + CPB * (1 + i) + CPB / 2];
    return d;
  endfunction

  function automatic logic framed(input int s);
    return (cap[s + CPB / 2] == 1'b0) && (cap[s + 9 * CPB + CPB / 2] == 1'b1);
  endfunction

  function automatic logic all_high(input int from, input int to);
    logic ok;
    ok = 1'b1;
    for (int i = from; i <= to; i++) if (cap[i] !== 1'b1) ok = 1'b0;
    return ok;
  endfunction

  task automatic test_reset();
    logic [3:0] got;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      got = {txd, busy, fifo_level == '0, overflow};
      n_checks++;
      if (got !== 4'b1010) begin
        n_errors++;
        $display("FAIL reset_idle cycle %0d got txd/busy/lvl0/ovf=%b exp 1010", k, got);
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] exp_byte;
    logic       exp_txd;
    logic       exp_busy;
    int         off;
    exp_byte  = 8'hA5;
    uart_dout = 32'h0000_00A5;
    uart_we   = 1'b1;
    tick();
    uart_we = 1'b0;
    n_checks++;
    if (fifo_level !== 3'd1 || busy !== 1'b1 || txd !== 1'b1) begin
      n_errors++;
      $display("FAIL single_write lvl=%0d busy=%b txd=%b exp 1 1 1", fifo_level, busy, txd);
    end
    for (int k = 1; k <= 41; k++) begin
      tick();
      off = k - 1;
      if (off < CPB)          exp_txd = 1'b0;
      else if (off < 9 * CPB) exp_txd = exp_byte[(off - CPB) / CPB];
      else                    exp_txd = 1'b1;
      exp_busy = (k <= 40);
      n_checks++;
      if (txd !== exp_txd || busy !== exp_busy) begin
        n_errors++;
        $display("FAIL single_frame edge N+%0d txd=%b busy=%b exp %b %b", k, txd, busy, exp_txd, exp_busy);
      end
      if (k == 1) begin
        n_checks++;
        if (fifo_level !== 3'd0) begin
          n_errors++;
          $display("FAIL single_pop lvl=%0d exp 0", fifo_level);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [3];
    logic [2:0] exp_lvl [3];
    exp_b   = '{8'h11, 8'h22, 8'h33};
    exp_lvl = '{3'd1, 3'd1, 3'd2};
    start_log();
    for (int k = 0; k < 130; k++) begin
      uart_we   = (k < 3);
      uart_dout = (k < 3) ? {24'hC0FFEE, exp_b[k]} : '0;
      tick_rec();
      if (k < 3) begin
        n_checks++;
        if (fifo_level !== exp_lvl[k]) begin
          n_errors++;
          $display("FAIL b2b_level edge %0d lvl=%0d exp %0d", k, fifo_level, exp_lvl[k]);
        end
      end
    end
    uart_we = 1'b0;
    for (int j = 0; j < 3; j++) begin
      n_checks++;
      if (decode(1 + PERIOD * j) !== exp_b[j] || !framed(1 + PERIOD * j)) begin
        n_errors++;
        $display("FAIL b2b_frame %0d got %h framed=%b exp %h", j, decode(1 + PERIOD * j),
                 framed(1 + PERIOD * j), exp_b[j]);
      end
      n_checks++;
      if (cap[1 + PERIOD * j + FRAME] !== 1'b1) begin
        n_errors++;
        $display("FAIL b2b_gap after frame %0d txd=%b exp 1", j, cap[1 + PERIOD * j + FRAME]);
      end
    end
    n_checks++;
    if (cap[1 + PERIOD] !== 1'b0 || cap[1 + 2 * PERIOD] !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_restart starts txd=%b,%b exp 0,0", cap[1 + PERIOD], cap[1 + 2 * PERIOD]);
    end
    n_checks++;
    if (peak_level !== 3'd2 || ovf_seen !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_peak peak=%0d ovf=%b exp 2 0", peak_level, ovf_seen);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_b [5];
    exp_b = '{8'h77, 8'h01, 8'h02, 8'h03, 8'h04};
    start_log();
    for (int k = 0; k < 260; k++) begin
      uart_we        = (k == 0) || (k >= 5 && k <= 11);
      uart_dout      = (k == 0) ? 32'h0000_0077 : {24'hABCDEF, 8'(k - 4)};
      clear_overflow = (k == 11) || (k == 12);
      tick_rec();
      if (k == 8) begin
        n_checks++;
        if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
          n_errors++;
          $display("FAIL ovf_fill lvl=%0d ovf=%b exp 4 0", fifo_level, overflow);
        end
      end
      if (k == 9) begin
        n_checks++;
        if (overflow !== 1'b1 || fifo_level !== 3'd4) begin
          n_errors++;
          $display("FAIL ovf_drop ovf=%b lvl=%0d exp 1 4", overflow, fifo_level);
        end
      end
      if (k == 11) begin
        n_checks++;
        if (overflow !== 1'b1) begin
          n_errors++;
          $display("FAIL ovf_set_wins ovf=%b exp 1", overflow);
        end
      end
      if (k == 12) begin
        n_checks++;
        if (overflow !== 1'b0) begin
          n_errors++;
          $display("FAIL ovf_clear ovf=%b exp 0", overflow);
        end
      end
    end
    uart_we        = 1'b0;
    clear_overflow = 1'b0;
    for (int j = 0; j < 5; j++) begin
      n_checks++;
      if (decode(1 + PERIOD * j) !== exp_b[j] || !framed(1 + PERIOD * j)) begin
        n_errors++;
        $display("FAIL ovf_frame %0d got %h framed=%b exp %h", j, decode(1 + PERIOD * j),
                 framed(1 + PERIOD * j), exp_b[j]);
      end
    end
    n_checks++;
    if (!all_high(1 + 4 * PERIOD + FRAME, 259) || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL ovf_no_extra line_idle=%b busy=%b exp 1 0",
               all_high(1 + 4 * PERIOD + FRAME, 259), busy);
    end
  endtask

  task automatic test_full_pop_edge();
    start_log();
    for (int k = 0; k < 260; k++) begin
      uart_we   = (k == 0) || (k >= 2 && k <= 5) || (k == 42);
      uart_dout = (k == 0) ? 32'h0000_0080 : (k == 42) ? 32'h1234_5685 : {24'h0, 8'(8'h80 + k - 1)};
      tick_rec();
      if (k == 41 || k == 42) begin
        n_checks++;
        if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
          n_errors++;
          $display("FAIL pop_edge edge %0d lvl=%0d ovf=%b exp 4 0", k, fifo_level, overflow);
        end
      end
    end
    uart_we = 1'b0;
    for (int j = 0; j < 6; j++) begin
      n_checks++;
      if (decode(1 + PERIOD * j) !== 8'(8'h80 + j) || !framed(1 + PERIOD * j)) begin
        n_errors++;
        $display("FAIL pop_edge_frame %0d got %h framed=%b exp %h", j, decode(1 + PERIOD * j),
                 framed(1 + PERIOD * j), 8'(8'h80 + j));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    start_log();
    for (int k = 0; k < 100; k++) begin
      reset     = (k == 18);
      uart_we   = (k == 0) || (k == 1) || (k == 25);
      uart_dout = (k == 0) ? 32'h0000_00C5 : (k == 1) ? 32'h0000_0099 : 32'h0000_005A;
      tick_rec();
      if (k == 17) begin
        n_checks++;
        if (txd !== 1'b0 || fifo_level !== 3'd1) begin
          n_errors++;
          $display("FAIL mid_bit3 txd=%b lvl=%0d exp 0 1", txd, fifo_level);
        end
      end
      if (k >= 18 && k <= 25) begin
        n_checks++;
        if (txd !== 1'b1 || busy !== (k == 25) || fifo_level !== 3'(k == 25)) begin
          n_errors++;
          $display("FAIL mid_reset edge %0d txd=%b busy=%b lvl=%0d", k, txd, busy, fifo_level);
        end
      end
    end
    reset   = 1'b0;
    uart_we = 1'b0;
    n_checks++;
    if (decode(26) !== 8'h5A || !framed(26)) begin
      n_errors++;
      $display("FAIL mid_reset_frame got %h framed=%b exp 5a", decode(26), framed(26));
    end
    n_checks++;
    if (!all_high(26 + FRAME, 99) || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_reset_discard line_idle=%b busy=%b exp 1 0", all_high(26 + FRAME, 99), busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pop_edge();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
